mr_scoreboard: RTL and testbench
================================

MR_SCOREBOARD -- requirements
Module: mr_scoreboard

Interface
REQ-001 The block SHALL use one clock and one reset: a single clock `clk`, and an asynchronous, active-low reset `rst_n`.

Parameters (name, default, meaning):
REQ-002 NREGS, 32: architectural registers tracked; index 0 is hardwired-zero and never tracked.
REQ-003 CNT_W, 2: width of each per-register pending-write counter; counter maximum CMAX = 2^CNT_W-1.
REQ-004 NWB, 2: number of independent writeback/retire ports (e.g. ALU writeback and CSR return).
REQ-005 MAX_INFL, 4: maximum in-flight instructions; INFL_W = $clog2(MAX_INFL+1).

Ports (name, direction, width, meaning), with RS = $clog2(NREGS):
REQ-006 clk, in, 1: clock.
REQ-007 rst_n, in, 1: asynchronous active-low reset.
REQ-008 chk_rs1 / chk_rs2 / chk_rd, in, RS each: source and destination indices of the candidate instruction.
REQ-009 chk_use_rs1 / chk_use_rs2 / chk_use_rd, in, 1 each: operand-used qualifiers.
REQ-010 chk_is_br, in, 1: candidate is a branch or jump.
REQ-011 stall, out, 1: combinational; candidate must not issue.
REQ-012 issue, in, 1: candidate dispatched this cycle.
REQ-013 wb_valid, in, NWB: per-port retire strobe.
REQ-014 wb_reg, in, NWB*RS: per-port destination index; port k occupies bits [k*RS +: RS].
REQ-015 wb_wr, in, NWB: retire also writes a register (0 = non-writing retire, e.g. store or branch).
REQ-016 jmp_done, in, 1: outstanding branch resolved.
REQ-017 jmp_pending, out, 1: registered.
REQ-018 inflight, out, INFL_W: registered count of issued, unretired instructions.
REQ-019 err, out, 3: sticky {inflight_underflow, counter_underflow, issue_while_stall}.

Function
REQ-020 A source hazard SHALL exist iff use_rsN & rsN!=0 & cnt[rsN]!=0.
REQ-021 A destination-full hazard SHALL exist iff chk_use_rd & chk_rd!=0 & cnt[chk_rd]==CMAX.
REQ-022 stall SHALL be the OR of: any source hazard; the destination-full hazard; jmp_pending; inflight==MAX_INFL.
REQ-023 stall SHALL be independent of issue and of same-cycle wb_valid; there is no writeback bypass.
REQ-024 On issue, cnt[chk_rd] SHALL increment when chk_use_rd & chk_rd!=0.
REQ-025 On issue, inflight SHALL increment.
REQ-026 On issue, jmp_pending SHALL set if chk_is_br.
REQ-027 For each port k with wb_valid[k], inflight SHALL decrement by one.
REQ-028 For each port k with wb_valid[k] & wb_wr[k] & wb_reg_k!=0, cnt[wb_reg_k] SHALL decrement by one.
REQ-029 All same-cycle increments and decrements to one counter SHALL be summed into a single net update, e.g. issue +1 and two ports -1 each on the same register gives net -1.
REQ-030 inflight SHALL net all events in one update: +issue, minus popcount(wb_valid).
REQ-031 A decrement that would take cnt below 0 SHALL clamp the counter at 0 and set err[1].
REQ-032 A decrement that would take inflight below 0 SHALL clamp inflight at 0 and set err[2].
REQ-033 issue asserted while stall=1 SHALL set err[0].
REQ-034 issue asserted while stall=1 SHALL still apply its updates, saturating cnt at CMAX and inflight at MAX_INFL.
REQ-035 jmp_done SHALL clear jmp_pending.
REQ-036 If issue of a branch and jmp_done occur in the same cycle, jmp_pending SHALL end at 1 (set wins).
REQ-037 All state updates SHALL take effect at the clock edge following the event; latency from issue to visible stall is 1 cycle.
REQ-038 Index 0 SHALL never be tracked and SHALL always read cnt 0.

Reset
REQ-039 While rst_n=0, all cnt SHALL be 0, inflight=0, jmp_pending=0 and err=0, asynchronously.
REQ-040 While rst_n=0, stall SHALL be forced to 1.
REQ-041 Reset asserted mid-operation SHALL discard all pending state.
REQ-042 After rst_n rises, the first clock edge SHALL accept issue.

Verification
REQ-043 Source hazard: issue rd=5, then check rs1=5 -> stall=1; wb port0 reg5 -> stall=0 next cycle, cnt[5]=0.
REQ-044 Simultaneous events: cnt[7]=2, same cycle issue rd=7 + wb port0 reg7 + wb port1 reg7 -> cnt[7]=1 and inflight decreases by 1.
REQ-045 Saturation (CNT_W=2): three issues to rd=3 -> cnt=3 and a fourth candidate with rd=3 sees stall=1; forced issue sets err[0] and cnt stays 3.
REQ-046 Branch: issue with chk_is_br -> jmp_pending=1 and stall=1; jmp_done together with a new branch issue -> jmp_pending stays 1.
REQ-047 Limits: with MAX_INFL=4, four issues -> stall=1; wb with cnt=0 sets err[1]; x0 destination never stalls; rst_n low mid-stream -> all counters read 0 immediately.

Source files
------------

// File: rtl/mr_scoreboard_if.sv
// Scoreboard port bundle: candidate check, issue, writeback/retire and branch resolution.
// master drives the candidate and events; slave is the scoreboard itself.
interface mr_scoreboard_if #(
    parameter int NREGS    = 32,
    parameter int NWB      = 2,
    parameter int MAX_INFL = 4
);
    localparam int RS     = $clog2(NREGS);
    localparam int INFL_W = $clog2(MAX_INFL + 1);

    logic [RS-1:0]     chk_rs1;
    logic [RS-1:0]     chk_rs2;
    logic [RS-1:0]     chk_rd;
    logic              chk_use_rs1;
    logic              chk_use_rs2;
    logic              chk_use_rd;
    logic              chk_is_br;
    logic              stall;
    logic              issue;
    logic [NWB-1:0]    wb_valid;
    logic [NWB*RS-1:0] wb_reg;
    logic [NWB-1:0]    wb_wr;
    logic              jmp_done;
    logic              jmp_pending;
    logic [INFL_W-1:0] inflight;
    logic [2:0]        err;

    modport master (
        output chk_rs1, chk_rs2, chk_rd, chk_use_rs1, chk_use_rs2, chk_use_rd, chk_is_br,
        output issue, wb_valid, wb_reg, wb_wr, jmp_done,
        input  stall, jmp_pending, inflight, err
    );

    modport slave (
        input  chk_rs1, chk_rs2, chk_rd, chk_use_rs1, chk_use_rs2, chk_use_rd, chk_is_br,
        input  issue, wb_valid, wb_reg, wb_wr, jmp_done,
        output stall, jmp_pending, inflight, err
    );
endinterface

// File: rtl/mr_scoreboard.sv
// In-order issue scoreboard: per-register pending-write counters, in-flight count and
// branch-pending flag; raises stall on RAW, destination-full, branch or capacity hazards.
module mr_sb_cnt #(
    parameter int CNT_W = 2,
    parameter int DW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic [DW-1:0]    dec,
    output logic [CNT_W-1:0] cnt,
    output logic             uflow
);
    localparam int CMAX = (1 << CNT_W) - 1;

    // Net all same-cycle events first, then clamp once.
    int nxt;
    always_comb nxt = int'(cnt) + int'(inc) - int'(dec);
    assign uflow = (nxt < 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          cnt <= '0;
        else if (nxt < 0)    cnt <= '0;
        else if (nxt > CMAX) cnt <= CNT_W'(CMAX);
        else                 cnt <= CNT_W'(nxt);
    end
endmodule

module mr_scoreboard #(
    parameter int NREGS    = 32,
    parameter int CNT_W    = 2,
    parameter int NWB      = 2,
    parameter int MAX_INFL = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mr_scoreboard_if.slave sb
);
    localparam int RS     = $clog2(NREGS);
    localparam int INFL_W = $clog2(MAX_INFL + 1);
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int DW     = $clog2(NWB + 1);

    logic [NREGS-1:0][CNT_W-1:0] cnt;
    logic [NREGS-1:0]            uflow;
    logic [NWB-1:0][RS-1:0]      wb_idx;
    logic [INFL_W-1:0]           inflight_q;
    logic                        jmp_q;
    logic [2:0]                  err_q;
    logic                        haz_rs1, haz_rs2, haz_rd, stall;
    int                          inf_nxt;

    assign wb_idx = sb.wb_reg;

    // x0 is never tracked: its counter is a constant zero.
    assign cnt[0]   = '0;
    assign uflow[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_reg
        logic          inc;
        logic [DW-1:0] dec;

        always_comb begin
            inc = sb.issue & sb.chk_use_rd & (sb.chk_rd == RS'(r));
            dec = '0;
            for (int k = 0; k < NWB; k++)
                if (sb.wb_valid[k] & sb.wb_wr[k] & (wb_idx[k] == RS'(r)))
                    dec += DW'(1);
        end

        mr_sb_cnt #(.CNT_W(CNT_W), .DW(DW)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc),
            .dec   (dec),
            .cnt   (cnt[r]),
            .uflow (uflow[r])
        );
    end

    // No writeback bypass: hazards look only at registered state.
    always_comb begin
        haz_rs1 = sb.chk_use_rs1 && (sb.chk_rs1 != '0) && (cnt[sb.chk_rs1] != '0);
        haz_rs2 = sb.chk_use_rs2 && (sb.chk_rs2 != '0) && (cnt[sb.chk_rs2] != '0);
        haz_rd  = sb.chk_use_rd  && (sb.chk_rd  != '0) && (cnt[sb.chk_rd] == CNT_W'(CMAX));
        stall   = !rst_n || haz_rs1 || haz_rs2 || haz_rd || jmp_q
                  || (inflight_q == INFL_W'(MAX_INFL));
    end

    always_comb inf_nxt = int'(inflight_q) + int'(sb.issue) - $countones(sb.wb_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            jmp_q      <= 1'b0;
            err_q      <= '0;
        end else begin
            if (inf_nxt < 0)             inflight_q <= '0;
            else if (inf_nxt > MAX_INFL) inflight_q <= INFL_W'(MAX_INFL);
            else                         inflight_q <= INFL_W'(inf_nxt);
            // A branch issuing in the same cycle as a resolve keeps the flag set.
            if (sb.issue && sb.chk_is_br) jmp_q <= 1'b1;
            else if (sb.jmp_done)         jmp_q <= 1'b0;
            err_q <= err_q | {inf_nxt < 0, |uflow, sb.issue & stall};
        end
    end

    assign sb.stall       = stall;
    assign sb.inflight    = inflight_q;
    assign sb.jmp_pending = jmp_q;
    assign sb.err         = err_q;
endmodule

// File: tb/tb_mr_scoreboard.sv
// Scoreboard bench: directed scenarios plus random traffic checked against a
// rule-level model (integer counters per register, clamped after netting).
module tb_mr_scoreboard;
    localparam int NREGS    = 32;
    localparam int CNT_W    = 2;
    localparam int NWB      = 2;
    localparam int MAX_INFL = 4;
    localparam int RS       = $clog2(NREGS);
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mr_scoreboard_if #(.NREGS(NREGS), .NWB(NWB), .MAX_INFL(MAX_INFL)) sb_if ();

    mr_scoreboard #(.NREGS(NREGS), .CNT_W(CNT_W), .NWB(NWB), .MAX_INFL(MAX_INFL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if)
    );

    int total = 0;
    int bad   = 0;

    int       mcnt [NREGS];
    int       minfl;
    bit       mjmp;
    bit [2:0] merr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit m_stall();
        return (sb_if.chk_use_rs1 && sb_if.chk_rs1 != 0 && mcnt[sb_if.chk_rs1] != 0)
            || (sb_if.chk_use_rs2 && sb_if.chk_rs2 != 0 && mcnt[sb_if.chk_rs2] != 0)
            || (sb_if.chk_use_rd  && sb_if.chk_rd  != 0 && mcnt[sb_if.chk_rd] == CMAX)
            || mjmp || (minfl == MAX_INFL);
    endfunction

    task automatic m_reset();
        foreach (mcnt[r]) mcnt[r] = 0;
        minfl = 0;
        mjmp  = 0;
        merr  = 0;
    endtask

    task automatic m_update(input bit st);
        int d [NREGS];
        int v;
        int rr;
        foreach (d[r]) d[r] = 0;
        if (sb_if.issue && st) merr[0] = 1;
        if (sb_if.issue && sb_if.chk_use_rd && sb_if.chk_rd != 0) d[sb_if.chk_rd]++;
        v = minfl + (sb_if.issue ? 1 : 0);
        for (int k = 0; k < NWB; k++) begin
            rr = int'(sb_if.wb_reg[k*RS +: RS]);
            if (sb_if.wb_valid[k]) v--;
            if (sb_if.wb_valid[k] && sb_if.wb_wr[k] && rr != 0) d[rr]--;
        end
        if (v < 0) begin v = 0; merr[2] = 1; end
        if (v > MAX_INFL) v = MAX_INFL;
        minfl = v;
        for (int r = 1; r < NREGS; r++) begin
            v = mcnt[r] + d[r];
            if (v < 0) begin v = 0; merr[1] = 1; end
            if (v > CMAX) v = CMAX;
            mcnt[r] = v;
        end
        if (sb_if.issue && sb_if.chk_is_br) mjmp = 1;
        else if (sb_if.jmp_done)            mjmp = 0;
    endtask

    task automatic idle();
        sb_if.chk_rs1 = '0; sb_if.chk_rs2 = '0; sb_if.chk_rd = '0;
        sb_if.chk_use_rs1 = 0; sb_if.chk_use_rs2 = 0; sb_if.chk_use_rd = 0;
        sb_if.chk_is_br = 0; sb_if.issue = 0; sb_if.jmp_done = 0;
        sb_if.wb_valid = '0; sb_if.wb_wr = '0; sb_if.wb_reg = '0;
    endtask

    task automatic cand(input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit ud, input bit br);
        sb_if.chk_rs1 = RS'(rs1); sb_if.chk_use_rs1 = u1;
        sb_if.chk_rs2 = RS'(rs2); sb_if.chk_use_rs2 = u2;
        sb_if.chk_rd  = RS'(rd);  sb_if.chk_use_rd  = ud;
        sb_if.chk_is_br = br;
    endtask

    task automatic set_wb(input int k, input bit wr, input int r);
        sb_if.wb_valid[k] = 1'b1;
        sb_if.wb_wr[k]    = wr;
        sb_if.wb_reg[k*RS +: RS] = RS'(r);
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic step(input string tag);
        bit st;
        st = m_stall();
        #1 check({tag, ".stall"}, sb_if.stall, st);
        @(posedge clk);
        m_update(st);
        @(negedge clk);
        check({tag, ".inflight"}, sb_if.inflight, minfl);
        check({tag, ".jmp"}, sb_if.jmp_pending, mjmp);
        check({tag, ".err"}, sb_if.err, merr);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        idle();
        #1;
        check({tag, ".rst_stall"}, sb_if.stall, 1);
        check({tag, ".rst_inflight"}, sb_if.inflight, 0);
        check({tag, ".rst_jmp"}, sb_if.jmp_pending, 0);
        check({tag, ".rst_err"}, sb_if.err, 0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_cycle(input bit allow_bad);
        int tmp [NREGS];
        int avail;
        int r;
        idle();
        cand($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
             1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
             $urandom_range(0, 7) == 0);
        if (allow_bad) sb_if.issue = ($urandom_range(0, 2) == 0);
        else           sb_if.issue = !m_stall() && ($urandom_range(0, 1) == 1);
        tmp   = mcnt;
        avail = minfl;
        for (int k = 0; k < NWB; k++) begin
            if ($urandom_range(0, 1) == 1 && (allow_bad || avail > 0)) begin
                avail--;
                if (allow_bad) begin
                    set_wb(k, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
                end else begin
                    r = $urandom_range(1, 7);
                    for (int t = 0; t < 7 && tmp[r] == 0; t++) r = r % 7 + 1;
                    if (tmp[r] > 0) begin
                        tmp[r]--;
                        set_wb(k, 1'b1, r);
                    end else begin
                        set_wb(k, 1'b0, r);
                    end
                end
            end
        end
        if (mjmp && $urandom_range(0, 3) == 0) sb_if.jmp_done = 1'b1;
        step("rnd");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        idle();
        m_reset();
        do_reset("r0");

        // RAW hazard on x5 and its release by writeback, with no bypass
        idle(); cand(0, 0, 0, 0, 5, 1, 0); sb_if.issue = 1; step("raw.issue");
        idle(); cand(5, 1, 0, 0, 0, 0, 0); step("raw.hold");
        check("raw.stall1", sb_if.stall, 1);
        idle(); cand(5, 1, 0, 0, 0, 0, 0); set_wb(0, 1, 5); step("raw.wb");
        idle(); cand(5, 1, 0, 0, 0, 0, 0); step("raw.free");
        check("raw.stall0", sb_if.stall, 0);
        check("raw.infl0", sb_if.inflight, 0);

        // Netting: cnt[7]=2, issue +1 and two writebacks -1 each
        idle(); cand(0, 0, 0, 0, 7, 1, 0); sb_if.issue = 1; step("net.i1");
        idle(); cand(0, 0, 0, 0, 7, 1, 0); sb_if.issue = 1; step("net.i2");
        idle(); cand(0, 0, 0, 0, 7, 1, 0); sb_if.issue = 1;
        set_wb(0, 1, 7); set_wb(1, 1, 7); step("net.mix");
        check("net.infl", sb_if.inflight, 1);
        idle(); cand(7, 1, 0, 0, 0, 0, 0); step("net.busy");
        check("net.stall1", sb_if.stall, 1);
        idle(); set_wb(0, 1, 7); step("net.ret");
        idle(); cand(7, 1, 0, 0, 0, 0, 0); step("net.free");
        check("net.stall0", sb_if.stall, 0);

        // Saturation of cnt[3] and a forced issue
        for (int i = 0; i < 3; i++) begin
            idle(); cand(0, 0, 0, 0, 3, 1, 0); sb_if.issue = 1; step("sat.issue");
        end
        idle(); cand(0, 0, 0, 0, 3, 1, 0); step("sat.full");
        check("sat.stall", sb_if.stall, 1);
        idle(); cand(0, 0, 0, 0, 3, 1, 0); sb_if.issue = 1; step("sat.force");
        check("sat.err0", sb_if.err, 3'b001);
        check("sat.infl4", sb_if.inflight, 4);
        idle(); set_wb(0, 0, 0); step("sat.ret_nw");
        idle(); cand(0, 0, 0, 0, 3, 1, 0); step("sat.still");
        check("sat.cnt3", sb_if.stall, 1);
        idle(); set_wb(0, 1, 3); set_wb(1, 1, 3); step("sat.ret2");
        idle(); set_wb(0, 1, 3); step("sat.ret1");
        idle(); cand(3, 1, 0, 0, 3, 1, 0); step("sat.empty");
        check("sat.err_keep", sb_if.err, 3'b001);

        // Branch pending; set wins over a same-cycle resolve
        do_reset("br");
        idle(); cand(0, 0, 0, 0, 0, 0, 1); sb_if.issue = 1; step("br.issue");
        check("br.jmp1", sb_if.jmp_pending, 1);
        idle(); step("br.wait");
        check("br.stall", sb_if.stall, 1);
        idle(); cand(0, 0, 0, 0, 0, 0, 1); sb_if.issue = 1; sb_if.jmp_done = 1; step("br.both");
        check("br.setwins", sb_if.jmp_pending, 1);
        idle(); sb_if.jmp_done = 1; step("br.done");
        check("br.jmp0", sb_if.jmp_pending, 0);
        idle(); set_wb(0, 0, 0); set_wb(1, 0, 0); step("br.ret");

        // Capacity, x0 destination, underflows
        do_reset("lim");
        for (int i = 0; i < MAX_INFL; i++) begin
            idle(); cand(0, 1, 0, 1, 0, 1, 0); sb_if.issue = 1; step("lim.x0");
        end
        idle(); step("lim.full");
        check("lim.stall", sb_if.stall, 1);
        idle(); set_wb(0, 1, 9); step("lim.cuf");
        check("lim.err1", sb_if.err, 3'b010);
        idle(); set_wb(0, 0, 0); set_wb(1, 0, 0); step("lim.r2");
        idle(); set_wb(0, 0, 0); set_wb(1, 0, 0); step("lim.iuf");
        check("lim.err2", sb_if.err, 3'b110);
        check("lim.infl0", sb_if.inflight, 0);

        // Reset in the middle of traffic drops all pending writes
        do_reset("mid0");
        idle(); cand(0, 0, 0, 0, 5, 1, 0); sb_if.issue = 1; step("mid.i5");
        idle(); cand(0, 0, 0, 0, 6, 1, 1); sb_if.issue = 1; step("mid.i6");
        do_reset("mid1");
        idle(); cand(5, 1, 6, 1, 0, 0, 0); step("mid.after");
        check("mid.stall0", sb_if.stall, 0);

        // Random legal traffic: err must stay clear
        do_reset("rl");
        for (int i = 0; i < 400; i++) rand_cycle(1'b0);
        check("rl.err", sb_if.err, 0);

        // Random traffic including forced issues and bogus retires
        do_reset("rb");
        for (int i = 0; i < 400; i++) rand_cycle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
